pipe_stage_skid: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage datapath. It replaces the fixed-field, always-load stage registers with a valid/ready stage that carries a generic data bus and control bundle. A two-entry skid buffer gives full throughput under downstream back-pressure. Flush inserts a bubble, and a saturating counter records back-pressure cycles for performance analysis.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_slot.sv | 41 ++++
 rtl/pipe_stage_skid.sv | 158 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
// Holds the default widths, the NOP control encoding and the skid-stage state encoding.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned CTRL_W_DEF = 9;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned ST_W       = 2;

  // All-zero control is the bubble; a cleared slot always carries this.
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  // Occupancy of the stage: EMPTY, main slot only, main plus skid slot.
  typedef enum logic [ST_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stateE;

endpackage

// File: rtl/pipe_slot.sv
// Single pipeline slot: valid flag plus payload and control, with load and clear.
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   load, clear         capture loadData/loadCtrl, or zero the slot (clear wins)
//   loadData, loadCtrl  value captured on load
//   valid, data, ctrl   registered slot contents
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] loadData,
  input  logic [CTRL_W-1:0] loadCtrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear has priority so a flushed or drained slot always reads as a NOP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
      ctrl  <= loadCtrl;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready inter-stage register with a two-entry skid buffer.
// Outputs come from the main slot M; the skid slot S absorbs the entry accepted
// in the cycle downstream stalls, so in_ready is a pure register decode.
// Ports:
//   clock, reset                 clock and asynchronous active-low reset
//   flush                        synchronous discard of held and incoming content
//   in_valid/in_ready            upstream handshake, in_data/in_ctrl payload
//   out_valid/out_ready          downstream handshake, out_data/out_ctrl payload
//   stall_count                  saturating count of out_valid & !out_ready cycles
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  stateE state;
  stateE nextState;

  logic              mLoad;
  logic              mClear;
  logic              mFromSkid;
  logic              sLoad;
  logic              sClear;
  logic              sValid;
  logic [DATA_W-1:0] sData;
  logic [CTRL_W-1:0] sCtrl;
  logic [DATA_W-1:0] mLoadData;
  logic [CTRL_W-1:0] mLoadCtrl;
  logic              inFire;
  logic              outFire;

  assign in_ready = !sValid;
  assign inFire   = in_valid & in_ready;
  assign outFire  = out_valid & out_ready;

  // M refills from S when draining FULL, otherwise from upstream.
  assign mLoadData = mFromSkid ? sData : in_data;
  assign mLoadCtrl = mFromSkid ? sCtrl : in_ctrl;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and slot control decode; flush overrides every handshake.
  always_comb begin
    nextState = state;
    mLoad     = 1'b0;
    mClear    = 1'b0;
    mFromSkid = 1'b0;
    sLoad     = 1'b0;
    sClear    = 1'b0;

    case (state)
      ST_EMPTY: begin
        if (inFire) begin
          mLoad     = 1'b1;
          nextState = ST_ONE;
        end
      end
      ST_ONE: begin
        if (inFire && outFire) begin
          mLoad = 1'b1;
        end else if (outFire) begin
          mClear    = 1'b1;
          nextState = ST_EMPTY;
        end else if (inFire) begin
          sLoad     = 1'b1;
          nextState = ST_FULL;
        end
      end
      ST_FULL: begin
        if (outFire) begin
          mLoad     = 1'b1;
          mFromSkid = 1'b1;
          sClear    = 1'b1;
          nextState = ST_ONE;
        end
      end
      default: begin
        mClear    = 1'b1;
        sClear    = 1'b1;
        nextState = ST_EMPTY;
      end
    endcase

    if (flush) begin
      mLoad     = 1'b0;
      sLoad     = 1'b0;
      mClear    = 1'b1;
      sClear    = 1'b1;
      nextState = ST_EMPTY;
    end
  end

  // Main slot: drives the stage outputs directly.
  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clock    (clock),
    .reset    (reset),
    .load     (mLoad),
    .clear    (mClear),
    .loadData (mLoadData),
    .loadCtrl (mLoadCtrl),
    .valid    (out_valid),
    .data     (out_data),
    .ctrl     (out_ctrl)
  );

  // Skid slot: holds the entry accepted while downstream stalled.
  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .load     (sLoad),
    .clear    (sClear),
    .loadData (in_data),
    .loadCtrl (in_ctrl),
    .valid    (sValid),
    .data     (sData),
    .ctrl     (sCtrl)
  );

  // Back-pressure counter; saturates and is cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: table-driven cycle vectors plus
// hand-written async-reset and counter-saturation sequences.
module tb_pipe_stage_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 9;

  logic          clock;
  logic          reset;
  logic          flush;
  logic          inValid;
  logic [DW-1:0] inData;
  logic [CW-1:0] inCtrl;
  logic          outReady;

  logic          inReady, inReadyS;
  logic          outValid, outValidS;
  logic [DW-1:0] outData, outDataS;
  logic [CW-1:0] outCtrl, outCtrlS;
  logic [15:0]   stallCount;
  logic [2:0]    stallS;

  int total = 0;
  int bad   = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clock (clock), .reset (reset), .flush (flush),
    .in_valid (inValid), .in_ready (inReady), .in_data (inData), .in_ctrl (inCtrl),
    .out_valid (outValid), .out_ready (outReady), .out_data (outData), .out_ctrl (outCtrl),
    .stall_count (stallCount)
  );

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dutSat (
    .clock (clock), .reset (reset), .flush (flush),
    .in_valid (inValid), .in_ready (inReadyS), .in_data (inData), .in_ctrl (inCtrl),
    .out_valid (outValidS), .out_ready (outReady), .out_data (outDataS), .out_ctrl (outCtrlS),
    .stall_count (stallS)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          rst;
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          eov;
    logic [DW-1:0] ed;
    logic          eir;
    int            es;
  } vecT;

  vecT vecs[$];

  function automatic void add(input logic rst, input logic fl, input logic iv,
                              input logic [DW-1:0] d, input logic ordy,
                              input logic eov, input logic [DW-1:0] ed,
                              input logic eir, input int es);
    vecT v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eov = eov; v.ed = ed; v.eir = eir; v.es = es;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idleInputs();
    flush    = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    inCtrl   = '0;
    outReady = 1'b0;
  endtask

  // Synchronous-looking reset pulse; ends on a falling edge.
  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    idleInputs();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idleInputs();
    #3;
    chk("reset_out_valid", 64'(outValid), 64'd0);
    chk("reset_in_ready", 64'(inReady), 64'd1);
    chk("reset_stall", 64'(stallCount), 64'd0);

    // Streaming 1..8
    add(1, 0, 1, 1, 1, 1, 1, 1, 0);
    for (int k = 2; k <= 8; k++) add(0, 0, 1, DW'(k), 1, 1, DW'(k), 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    // Back-pressure: entry 2 stalled for 3 cycles
    add(1, 0, 1, 1, 1, 1, 1, 1, 0);
    add(0, 0, 1, 2, 1, 1, 2, 1, 0);
    add(0, 0, 1, 3, 0, 1, 2, 0, 1);
    add(0, 0, 1, 4, 0, 1, 2, 0, 2);
    add(0, 0, 1, 4, 0, 1, 2, 0, 3);
    add(0, 0, 1, 4, 1, 1, 3, 1, 3);
    add(0, 0, 1, 4, 1, 1, 4, 1, 3);
    add(0, 0, 0, 0, 1, 0, 0, 1, 3);
    // Flush in FULL with an incoming 0x55
    add(1, 0, 1, 32'hA, 0, 1, 32'hA, 1, 0);
    add(0, 0, 1, 32'hB, 0, 1, 32'hA, 0, 1);
    add(0, 1, 1, 32'h55, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1);
    // Flush together with out_fire in ONE, then 0x9 with one-cycle latency
    add(1, 0, 1, 32'h7, 1, 1, 32'h7, 1, 0);
    add(0, 1, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 1, 32'h9, 1, 1, 32'h9, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      else @(negedge clock);
      flush    = vecs[i].fl;
      inValid  = vecs[i].iv;
      inData   = vecs[i].d;
      inCtrl   = CW'(vecs[i].d);
      outReady = vecs[i].ordy;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(outValid), 64'(vecs[i].eov));
      chk($sformatf("v%0d_out_data", i), 64'(outData), 64'(vecs[i].ed));
      chk($sformatf("v%0d_out_ctrl", i), 64'(outCtrl), 64'(CW'(vecs[i].ed)));
      chk($sformatf("v%0d_in_ready", i), 64'(inReady), 64'(vecs[i].eir));
      if (vecs[i].es >= 0)
        chk($sformatf("v%0d_stall", i), 64'(stallCount), 64'(vecs[i].es));
    end

    // Async reset while FULL, asserted between edges
    doReset();
    inValid = 1'b1; inData = 32'hA; inCtrl = 9'hA; outReady = 1'b0;
    @(negedge clock);
    inData = 32'hB; inCtrl = 9'hB;
    @(negedge clock);
    inValid = 1'b0;
    chk("full_in_ready", 64'(inReady), 64'd0);
    chk("full_stall", 64'(stallCount), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out_valid", 64'(outValid), 64'd0);
    chk("async_out_data", 64'(outData), 64'd0);
    chk("async_out_ctrl", 64'(outCtrl), 64'd0);
    chk("async_stall", 64'(stallCount), 64'd0);
    chk("async_in_ready", 64'(inReady), 64'd1);
    @(negedge clock);
    reset = 1'b1;

    // Saturation of the 3-bit counter over 10 stalled cycles
    doReset();
    inValid = 1'b1; inData = 32'h1; inCtrl = 9'h1; outReady = 1'b1;
    @(negedge clock);
    inValid = 1'b0; outReady = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
      if (c == 7) chk("sat_reach7", 64'(stallS), 64'd7);
    end
    chk("sat_hold7", 64'(stallS), 64'd7);
    chk("sat_wide10", 64'(stallCount), 64'd10);
    chk("sat_out_valid", 64'(outValidS), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
